// File: rtl/lut_bank_cfg_if.sv
// Lookup and configuration bundle for lut_bank_cfg.
// A beat transfers on any rising edge where cfg_valid and cfg_ready are both high; cfg_valid may drop at any time.
interface lut_bank_cfg_if #(
    parameter int K     = 4,
    parameter int CH    = 2,
    parameter int CFG_W = 8
);
    logic [CH*K-1:0]  lut_in;
    logic [CH-1:0]    lut_out;
    logic             cfg_start;
    logic             cfg_valid;
    logic [CFG_W-1:0] cfg_data;
    logic             cfg_ready;
    logic             cfg_busy;
    logic             cfg_done;
    logic [1:0]       dbg_state;

    modport master (
        output lut_in, cfg_start, cfg_valid, cfg_data,
        input  lut_out, cfg_ready, cfg_busy, cfg_done, dbg_state
    );

    modport slave (
        input  lut_in, cfg_start, cfg_valid, cfg_data,
        output lut_out, cfg_ready, cfg_busy, cfg_done, dbg_state
    );
endinterface

// File: rtl/lut_bank_cfg.sv
// Bank of CH runtime-reloadable K-input LUTs; tables load into a shadow store
// and swap into the active store in a single edge.
module lut_bank_cfg #(
    parameter int                        K       = 4,
    parameter int                        CH      = 2,
    parameter int                        CFG_W   = 8,
    parameter logic [CH*(2**K)-1:0]      INIT    = '0,
    parameter bit                        REG_OUT = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    lut_bank_cfg_if.slave  bus
);
    localparam int D  = 2**K;
    localparam int TW = CH*D;
    localparam int NB = TW/CFG_W;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    generate
        if (TW % CFG_W != 0) begin : g_bad_cfg_w
            $error("lut_bank_cfg: CH*2^K must be a multiple of CFG_W");
        end
    endgenerate

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]                 r_state;
    logic [CW-1:0]              r_cnt;
    logic [NB-1:0][CFG_W-1:0]   r_shadow;
    logic [TW-1:0]              r_active;
    logic                       r_done;
    logic                       w_last;
    logic [CH-1:0]              w_lut;

    assign w_last = (r_cnt == CW'(NB-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_shadow <= INIT;
            r_active <= INIT;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_COMMIT);
            case (r_state)
                S_IDLE: begin
                    if (bus.cfg_start) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    // A restart wins over a beat presented in the same cycle.
                    if (bus.cfg_start) begin
                        r_cnt <= '0;
                    end else if (bus.cfg_valid) begin
                        r_shadow[r_cnt] <= bus.cfg_data;
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= S_COMMIT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    r_active <= r_shadow;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    genvar c;
    generate
        for (c = 0; c < CH; c++) begin : g_ch
            logic [D-1:0] w_tab;
            assign w_tab    = r_active[c*D +: D];
            assign w_lut[c] = w_tab[bus.lut_in[c*K +: K]];
        end

        if (REG_OUT) begin : g_reg_out
            logic [CH-1:0] r_out;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_out <= '0;
                else        r_out <= w_lut;
            end
            assign bus.lut_out = r_out;
        end else begin : g_comb_out
            assign bus.lut_out = w_lut;
        end
    endgenerate

    assign bus.cfg_ready = (r_state == S_SHIFT);
    assign bus.cfg_busy  = (r_state != S_IDLE);
    assign bus.cfg_done  = r_done;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_lut_bank_cfg.sv
// Randomized bench for lut_bank_cfg: registered and combinational instances
// share stimulus and are checked against a table/queue model.
module tb_lut_bank_cfg;
    localparam int K     = 4;
    localparam int CH    = 2;
    localparam int CFG_W = 8;
    localparam int NB    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lut_bank_cfg_if #(.K(K), .CH(CH), .CFG_W(CFG_W)) bus1 ();
    lut_bank_cfg_if #(.K(K), .CH(CH), .CFG_W(CFG_W)) bus0 ();

    lut_bank_cfg #(.K(K), .CH(CH), .CFG_W(CFG_W), .INIT('0), .REG_OUT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    lut_bank_cfg #(.K(K), .CH(CH), .CFG_W(CFG_W), .INIT('0), .REG_OUT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));

    assign bus0.lut_in    = bus1.lut_in;
    assign bus0.cfg_start = bus1.cfg_start;
    assign bus0.cfg_valid = bus1.cfg_valid;
    assign bus0.cfg_data  = bus1.cfg_data;

    int n_cmp = 0;
    int n_bad = 0;
    // {ready, busy, done, out_registered[1:0], out_comb[1:0]}
    logic [6:0] exp_q[$];

    // Reference model: the active tables as one vector, a load as a list of accepted beats.
    logic [31:0] m_active;
    logic [31:0] m_pending;
    logic        m_loading;
    logic        m_commit;
    logic [7:0]  m_beats[$];
    logic [1:0]  m_o1;
    logic        m_done;

    function automatic logic [1:0] look(input logic [31:0] tab, input logic [7:0] sel);
        logic [1:0] r;
        for (int ch = 0; ch < CH; ch++) r[ch] = tab[ch*16 + int'(sel[ch*4 +: 4])];
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active  = '0;
            m_pending = '0;
            m_loading = 1'b0;
            m_commit  = 1'b0;
            m_beats.delete();
            exp_q.push_back({3'b000, 2'b00, look(32'h0, bus1.lut_in)});
        end else begin
            m_o1   = look(m_active, bus1.lut_in);
            m_done = 1'b0;
            if (m_commit) begin
                m_active = m_pending;
                m_commit = 1'b0;
                m_done   = 1'b1;
            end else if (!m_loading) begin
                if (bus1.cfg_start) begin
                    m_loading = 1'b1;
                    m_beats.delete();
                end
            end else if (bus1.cfg_start) begin
                m_beats.delete();
            end else if (bus1.cfg_valid) begin
                m_beats.push_back(bus1.cfg_data);
                if (m_beats.size() == NB) begin
                    for (int i = 0; i < NB; i++) m_pending[i*8 +: 8] = m_beats[i];
                    m_loading = 1'b0;
                    m_commit  = 1'b1;
                end
            end
            exp_q.push_back({m_loading, m_loading | m_commit, m_done, m_o1,
                             look(m_active, bus1.lut_in)});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [6:0] e;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("ready_reg",  {31'd0, bus1.cfg_ready}, {31'd0, e[6]});
            check("busy_reg",   {31'd0, bus1.cfg_busy},  {31'd0, e[5]});
            check("done_reg",   {31'd0, bus1.cfg_done},  {31'd0, e[4]});
            check("lut_out_reg",  {30'd0, bus1.lut_out}, {30'd0, e[3:2]});
            check("ready_comb", {31'd0, bus0.cfg_ready}, {31'd0, e[6]});
            check("busy_comb",  {31'd0, bus0.cfg_busy},  {31'd0, e[5]});
            check("done_comb",  {31'd0, bus0.cfg_done},  {31'd0, e[4]});
            check("lut_out_comb", {30'd0, bus0.lut_out}, {30'd0, e[1:0]});
        end
    end

    logic [63:0] xs = 64'h0123_4567_89AB_CDEF;
    bit          rand_in = 1'b0;

    function automatic logic [63:0] xs_step(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    task automatic cyc();
        @(negedge clk);
        #1;
        if (rand_in) begin
            xs = xs_step(xs);
            bus1.lut_in = xs[7:0];
        end
    endtask

    task automatic idle(input int n);
        bus1.cfg_valid = 1'b0;
        repeat (n) begin
            bus1.cfg_data = 8'($urandom);
            cyc();
        end
    endtask

    task automatic beat(input logic [7:0] d);
        bus1.cfg_valid = 1'b1;
        bus1.cfg_data  = d;
        cyc();
        bus1.cfg_valid = 1'b0;
        bus1.cfg_data  = 8'($urandom);
    endtask

    task automatic pulse_start(input bit with_beat);
        bus1.cfg_start = 1'b1;
        bus1.cfg_valid = with_beat;
        bus1.cfg_data  = 8'($urandom);
        cyc();
        bus1.cfg_start = 1'b0;
        bus1.cfg_valid = 1'b0;
    endtask

    task automatic load4(input logic [31:0] tab);
        pulse_start(1'b0);
        for (int i = 0; i < NB; i++) beat(tab[i*8 +: 8]);
    endtask

    task automatic rand_load();
        int n;
        pulse_start(1'($urandom_range(0, 1)));
        n = 0;
        while (n < NB) begin
            idle($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) begin
                pulse_start(1'b1);
                n = 0;
            end else begin
                beat(8'($urandom));
                n++;
            end
        end
        // Half the time, pulse start during the commit cycle.
        if ($urandom_range(0, 1) == 1) pulse_start(1'b0);
    endtask

    initial begin
        bus1.lut_in    = '0;
        bus1.cfg_start = 1'b0;
        bus1.cfg_valid = 1'b0;
        bus1.cfg_data  = '0;
        repeat (3) cyc();
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) begin
            bus1.lut_in = 8'(i);
            cyc();
        end

        // Channel 0 = ((a&~b)^c)|d, channel 1 = 4-input parity.
        load4(32'h6996_FFD2);
        rand_in = 1'b1;
        idle(10000);

        pulse_start(1'b0);
        beat(8'hD2); idle(2);
        beat(8'hFF); idle(2);
        beat(8'h96); idle(2);
        beat(8'h69);
        idle(40);

        pulse_start(1'b0);
        beat(8'hAA);
        beat(8'h55);
        pulse_start(1'b1);
        beat(8'h00); beat(8'h00); beat(8'hFF); beat(8'hFF);
        idle(40);

        rand_in = 1'b0;
        bus1.lut_in = 8'hFF;
        load4(32'hFFFF_FFFF);
        idle(4);
        load4(32'h0000_0000);
        idle(4);

        rand_in = 1'b1;
        load4(32'hA5A5_5A5A);
        idle(3);
        pulse_start(1'b0);
        beat(8'h12);
        beat(8'h34);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(30);

        for (int l = 0; l < 30; l++) begin
            rand_load();
            idle($urandom_range(0, 3));
        end
        idle(20);

        @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
